fetch_inst_buffer: RTL
======================

FETCH_INST_BUFFER -- requirements
Module: fetch_inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of fetchEntry_t slots (power of two, >= 2*ENQ_WIDTH).
REQ-002 SHALL have parameter ENQ_WIDTH, default 4, fetch lanes accepted per cycle.
REQ-003 SHALL have parameter DEQ_WIDTH, default 2, decode lanes presented per cycle.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_squash  in  1  pipeline squash; flush all contents.
REQ-007 SHALL have port i_enq_vld  in  ENQ_WIDTH  per-lane valid; set lanes contiguous from lane 0.
REQ-008 SHALL have port i_enq_entry  in  ENQ_WIDTH x fetchEntry_t  lane payloads, lane 0 oldest.
REQ-009 SHALL have port o_enq_rdy  out  1  buffer can take a full ENQ_WIDTH group this cycle.
REQ-010 SHALL have port o_deq_vld  out  DEQ_WIDTH  lane i valid when occupancy > i.
REQ-011 SHALL have port o_deq_entry  out  DEQ_WIDTH x fetchEntry_t  head entries, lane 0 oldest.
REQ-012 SHALL have port i_deq_rdy  in  1  decode consumes every valid o_deq lane this cycle.
REQ-013 SHALL have port o_count  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL be a circular FIFO; head/tail pointers clog2(DEPTH) bits plus wrap bit; index wraps modulo DEPTH.
REQ-015 SHALL set o_enq_rdy = (DEPTH - o_count >= ENQ_WIDTH), from registered count only; same-cycle dequeue does not raise it.
REQ-016 SHALL enqueue when o_enq_rdy & |i_enq_vld & !i_squash; writes lanes 0..k-1, k = popcount(i_enq_vld), at tail..tail+k-1; tail += k.
REQ-017 SHALL ignore i_enq_vld/i_enq_entry when o_enq_rdy = 0 (no partial acceptance).
REQ-018 SHALL drive o_deq_entry[i] = slot[(head+i) mod DEPTH], combinationally from storage; o_deq_vld[i] = (o_count > i).
REQ-019 SHALL, when i_deq_rdy & !i_squash, advance head by d = popcount(o_deq_vld).
REQ-020 SHALL update count = count + k - d on simultaneous enqueue/dequeue; never exceed DEPTH nor go below 0.
REQ-021 SHALL make an entry enqueued in cycle t visible on o_deq no earlier than cycle t+1 (no bypass).
REQ-022 SHALL preserve program order: dequeue order equals enqueue order across lanes and cycles, including wrap.
REQ-023 SHALL, when i_squash = 1, set head = tail = 0 and count = 0 next cycle; same-cycle enqueue and dequeue discarded; squash overrides all.
REQ-024 SHALL pass fetchEntry_t payload unmodified, including has_except/except and foldpc.
REQ-025 SHALL treat non-contiguous i_enq_vld as illegal; simulation assertion fires, RTL behaviour unspecified.

Reset
REQ-026 SHALL, when rst = 1 at a rising edge, set head = tail = 0, count = 0; o_deq_vld = 0, o_count = 0, o_enq_rdy = 1 from next cycle.
REQ-027 SHALL give rst priority over i_squash and all enq/deq; reset mid-operation drops all contents.
REQ-028 SHALL not reset storage slots; payload of invalid lanes is don't-care.

Structure
REQ-029 SHALL take fetchEntry_t, ftqIdx_t, ftqOffset_t from the shared core define header; add no new shared typedefs.
REQ-030 SHALL place FETCH_BUFFER_DEPTH and DECODE_WIDTH defaults in the core config header as shared constants.
REQ-031 SHALL isolate storage in one sub-module fetch_buffer_mem (ENQ_WIDTH write ports, DEQ_WIDTH read ports, no reset).

Verification
REQ-032 SHALL cover: reset, enq 4 lanes inst=0x1..0x4 -> next cycle o_deq_vld=2'b11 with 0x1,0x2; o_count=4.
REQ-033 SHALL cover: fill to 13 entries -> o_enq_rdy=0; enq attempt ignored, o_count stays 13; dequeue 2 -> o_count=11, o_enq_rdy=1.
REQ-034 SHALL cover: simultaneous enq 3 lanes and deq 2 at count=5 -> o_count=6, order preserved.
REQ-035 SHALL cover: 40 cycles streaming enq/deq past pointer wrap -> output sequence identical to input sequence.
REQ-036 SHALL cover: i_squash with count=9 plus same-cycle enq 4 and deq -> next cycle o_count=0, o_deq_vld=0, o_enq_rdy=1.
REQ-037 SHALL cover: count=1, i_deq_rdy=1 -> only lane 0 consumed, o_count=0; rst asserted mid-stream -> empty next cycle.

Source files
------------

// File: rtl/fetch_inst_buffer_pkg.sv
// fetch_inst_buffer_pkg: shared fetch/decode types and buffer sizing defaults
package fetch_inst_buffer_pkg;
  localparam int FETCH_BUFFER_DEPTH = 16;
  localparam int DECODE_WIDTH = 2;
  localparam int FETCH_WIDTH = 4;
  typedef logic [5:0] ftqIdx_t;
  typedef logic [3:0] ftqOffset_t;
  typedef struct packed {
    logic [31:0] inst;
    logic [9:0]  foldpc;
    logic        has_except;
    logic [3:0]  except;
    ftqIdx_t     ftq_idx;
    ftqOffset_t  ftq_offset;
  } fetchEntry_t;
endpackage

// File: rtl/fetch_buffer_mem.sv
// fetch_buffer_mem: unreset slot storage, multi-lane write, combinational multi-lane read
module fetch_buffer_mem
  import fetch_inst_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_BUFFER_DEPTH,
  parameter int WR = FETCH_WIDTH,
  parameter int RD = DECODE_WIDTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic [WR-1:0]          we,
  input  logic [WR-1:0][AW-1:0]  waddr,
  input  fetchEntry_t [WR-1:0]   wdata,
  input  logic [RD-1:0][AW-1:0]  raddr,
  output fetchEntry_t [RD-1:0]   rdata
);
  fetchEntry_t slot [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < WR; i++)
      if (we[i]) slot[waddr[i]] <= wdata[i];
  always_comb
    for (int i = 0; i < RD; i++)
      rdata[i] = slot[raddr[i]];
endmodule

// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: circular FIFO between fetch (wide enqueue) and decode (narrow dequeue)
module fetch_inst_buffer
  import fetch_inst_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_BUFFER_DEPTH,
  parameter int ENQ_WIDTH = FETCH_WIDTH,
  parameter int DEQ_WIDTH = DECODE_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_squash,
  input  logic [ENQ_WIDTH-1:0]          i_enq_vld,
  input  fetchEntry_t [ENQ_WIDTH-1:0]   i_enq_entry,
  output logic                          o_enq_rdy,
  output logic [DEQ_WIDTH-1:0]          o_deq_vld,
  output fetchEntry_t [DEQ_WIDTH-1:0]   o_deq_entry,
  input  logic                          i_deq_rdy,
  output logic [$clog2(DEPTH):0]        o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW:0] head, tail;
  logic [CW-1:0] count, k, d;
  logic do_enq, do_deq;
  logic [ENQ_WIDTH-1:0] we;
  logic [ENQ_WIDTH-1:0][AW-1:0] waddr;
  logic [DEQ_WIDTH-1:0][AW-1:0] raddr;
  assign k = CW'($countones(i_enq_vld));
  assign d = CW'($countones(o_deq_vld));
  assign o_enq_rdy = count <= CW'(DEPTH - ENQ_WIDTH);
  assign do_enq = o_enq_rdy && |i_enq_vld && !i_squash;
  assign do_deq = i_deq_rdy && !i_squash;
  assign o_count = count;
  always_comb begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      we[i] = do_enq && i_enq_vld[i];
      waddr[i] = tail[AW-1:0] + AW'(i);
    end
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      o_deq_vld[i] = count > CW'(i);
      raddr[i] = head[AW-1:0] + AW'(i);
    end
  end
  fetch_buffer_mem #(.DEPTH(DEPTH), .WR(ENQ_WIDTH), .RD(DEQ_WIDTH), .AW(AW)) u_mem (
    .clk(clk), .we(we), .waddr(waddr), .wdata(i_enq_entry), .raddr(raddr), .rdata(o_deq_entry)
  );
  always_ff @(posedge clk)
    if (rst || i_squash) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      tail <= tail + (do_enq ? k : '0);
      head <= head + (do_deq ? d : '0);
      count <= count + (do_enq ? k : '0) - (do_deq ? d : '0);
    end
  // Valid lanes must form a contiguous run starting at lane 0.
  always_ff @(posedge clk)
    if (!rst) assert ((i_enq_vld & (i_enq_vld + ENQ_WIDTH'(1))) == '0);
endmodule
